// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: collects 1-bit neuron spikes and serialises them into
// AER words (index of the neuron that fired) over a valid/ready handshake.
// Pending spikes are held while the consumer stalls; collisions are counted.
module spike_aer_encoder #(
    parameter int unsigned N_NEURONS  = 8,
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_NEURONS-1:0] spike_in,
    input  logic                 aer_ready,
    output logic                 aer_valid,
    output logic [ADDR_W-1:0]    aer_addr,
    output logic [7:0]           drop_count,
    output logic                 busy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [N_NEURONS-1:0] pending_q, pending_d;
    logic [ADDR_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           drop_q;

    logic                 found;
    logic [ADDR_W-1:0]    sel_idx;
    logic [N_NEURONS-1:0] sel_onehot;
    logic [N_NEURONS-1:0] clear_mask;
    logic                 full, empty, push, pop, collision;

    // Priority scanner: lowest-index pending bit wins.
    always_comb begin
        found      = 1'b0;
        sel_idx    = '0;
        sel_onehot = '0;
        for (int unsigned i = 0; i < N_NEURONS; i++) begin
            if (pending_q[i] && !found) begin
                found         = 1'b1;
                sel_idx       = ADDR_W'(i);
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // Handshake, push/pop decisions, collision detection and next pending.
    always_comb begin
        empty      = (cnt_q == '0);
        full       = (cnt_q == CNT_W'(FIFO_DEPTH));
        pop        = !empty && aer_ready;
        push       = found && (!full || pop);
        clear_mask = push ? sel_onehot : '0;
        collision  = |(spike_in & pending_q & ~clear_mask);
        pending_d  = (pending_q & ~clear_mask) | spike_in;
        cnt_d      = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Pending register, FIFO storage/pointers/occupancy and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            drop_q    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= sel_idx;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (collision && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    // Show-ahead outputs; address forced to zero when nothing is queued.
    always_comb begin
        aer_valid  = (cnt_q != '0);
        aer_addr   = aer_valid ? mem_q[rd_ptr_q] : '0;
        drop_count = drop_q;
        busy       = (pending_q != '0) || aer_valid;
    end

endmodule
